// File: rtl/ex_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_div_pkg
// Description : Shared constants for the EX-stage divider. Holds the divider
//               FSM state encodings, the signed/unsigned operation select
//               values and the stall-request levels driven on stop_o.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_div_pkg;

  // Divider FSM state encodings
  localparam logic [1:0] DivIdle = 2'd0;
  localparam logic [1:0] DivBusy = 2'd1;
  localparam logic [1:0] DivDone = 2'd2;

  // div_signed_i values
  localparam logic DivSigned   = 1'b1;
  localparam logic DivUnsigned = 1'b0;

  // Stall-request levels toward the pipeline controller
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

endpackage : ex_div_pkg
`default_nettype wire

// File: rtl/ex_div_step.sv
`default_nettype none
// ============================================================================
// Module      : ex_div_step
// Description : One combinational restoring-division iteration. Shifts
//               {rem, quot} left by one, trial-subtracts the divisor from the
//               WIDTH+1-bit partial remainder and keeps the difference (and
//               sets the new quotient LSB) when it is non-negative.
// Ports       : rem_i   - current partial remainder (always < divisor)
//               quot_i  - current quotient / remaining dividend bits
//               div_i   - divisor magnitude
//               rem_o   - next partial remainder
//               quot_o  - next quotient
// Revision    : 1.0 - initial release
// ============================================================================
module ex_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;

  assign w_rem_sh = {rem_i, quot_i[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, div_i};

  // The remainder stays below the divisor, so after either outcome the top
  // bit of the WIDTH+1-bit value is zero and WIDTH bits suffice.
  always_comb begin
    if (w_diff[WIDTH]) begin
      rem_o  = w_rem_sh[WIDTH-1:0];
      quot_o = {quot_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o  = w_diff[WIDTH-1:0];
      quot_o = {quot_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule : ex_div_step
`default_nettype wire

// File: rtl/ex_div.sv
`default_nettype none
// ============================================================================
// Module      : ex_div
// Description : Multi-cycle restoring divider for DIV/DIVU in the EX stage.
//               Requests a pipeline stall while busy, abandons work on
//               flush, and returns quotient (LO) and remainder (HI) with a
//               one-cycle ready strobe.
// Ports       : cpu_clk_75M  - clock
//               cpu_rst      - synchronous active-high reset
//               div_start_i  - DIV/DIVU present in EX (held while stalled)
//               div_signed_i - 1 = DIV, 0 = DIVU
//               dividend_i   - rs operand, sampled on accept
//               divisor_i    - rt operand, sampled on accept
//               flush_i      - controller flush, aborts any operation
//               stop_o       - stall request (stop_from_ex)
//               ready_o      - result-valid strobe
//               quot_o       - quotient
//               rem_o        - remainder
// Config      : DIV_ZERO_FAST_EN - when defined, a zero divisor skips the
//               iterations and completes one cycle after accept.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_div
  import ex_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             cpu_clk_75M,
  input  logic             cpu_rst,
  input  logic             div_start_i,
  input  logic             div_signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             flush_i,
  output logic             stop_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam logic [CNT_W-1:0] c_LAST_STEP = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_dividend;
  logic             r_q_sign;
  logic             r_r_sign;
  logic             r_dz;
  logic [WIDTH-1:0] r_quot_res;
  logic [WIDTH-1:0] r_rem_res;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_div_zero;
  logic             w_accept;
  logic             w_last_step;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quot_next;

  assign w_a_neg     = (div_signed_i == DivSigned) & dividend_i[WIDTH-1];
  assign w_b_neg     = (div_signed_i == DivSigned) & divisor_i[WIDTH-1];
  assign w_abs_a     = w_a_neg ? -dividend_i : dividend_i;
  assign w_abs_b     = w_b_neg ? -divisor_i  : divisor_i;
  assign w_div_zero  = (divisor_i == '0);
  assign w_accept    = (r_state == DivIdle) & div_start_i & ~flush_i;
  assign w_last_step = (r_cnt == c_LAST_STEP);

  ex_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_i  (r_rem),
    .quot_i (r_quot),
    .div_i  (r_div),
    .rem_o  (w_rem_next),
    .quot_o (w_quot_next)
  );

  // State register
  always_ff @(posedge cpu_clk_75M) begin
    if (cpu_rst) begin
      r_state <= DivIdle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      DivIdle: begin
        if (w_accept) begin
`ifdef DIV_ZERO_FAST_EN
          w_next_state = w_div_zero ? DivDone : DivBusy;
`else
          w_next_state = DivBusy;
`endif
        end
      end
      DivBusy: begin
        if (w_last_step) begin
          w_next_state = DivDone;
        end
      end
      DivDone: w_next_state = DivIdle;
      default: w_next_state = DivIdle;
    endcase
    if (flush_i) begin
      w_next_state = DivIdle;
    end
  end

  // Outputs; stop_o is combinational so the controller stalls in the accept
  // cycle, and drops in DONE so the pipeline advances with the result.
  always_comb begin
    stop_o  = NoStop;
    ready_o = 1'b0;
    case (r_state)
      DivIdle: if (div_start_i) stop_o = Stop;
      DivBusy: stop_o = Stop;
      DivDone: ready_o = 1'b1;
      default: ;
    endcase
    if (flush_i) begin
      stop_o  = NoStop;
      ready_o = 1'b0;
    end
  end

  // Datapath: operand latches, iteration registers and result registers.
  // Results are written on the edge entering DONE so they are valid while
  // ready_o is high, and then hold until the next completion.
  always_ff @(posedge cpu_clk_75M) begin
    if (cpu_rst) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_div      <= '0;
      r_dividend <= '0;
      r_q_sign   <= 1'b0;
      r_r_sign   <= 1'b0;
      r_dz       <= 1'b0;
      r_quot_res <= '0;
      r_rem_res  <= '0;
    end else if (flush_i) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        DivIdle: begin
          if (w_accept) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quot     <= w_abs_a;
            r_div      <= w_abs_b;
            r_dividend <= dividend_i;
            r_q_sign   <= w_a_neg ^ w_b_neg;
            r_r_sign   <= w_a_neg;
            r_dz       <= w_div_zero;
`ifdef DIV_ZERO_FAST_EN
            if (w_div_zero) begin
              r_quot_res <= '1;
              r_rem_res  <= dividend_i;
            end
`endif
          end
        end
        DivBusy: begin
          r_rem  <= w_rem_next;
          r_quot <= w_quot_next;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last_step) begin
            // Divide by zero bypasses sign correction entirely
            if (r_dz) begin
              r_quot_res <= '1;
              r_rem_res  <= r_dividend;
            end else begin
              r_quot_res <= r_q_sign ? -w_quot_next : w_quot_next;
              r_rem_res  <= r_r_sign ? -w_rem_next  : w_rem_next;
            end
          end
        end
        DivDone: r_cnt <= '0;
        default: r_cnt <= '0;
      endcase
    end
  end

  assign quot_o = r_quot_res;
  assign rem_o  = r_rem_res;

endmodule : ex_div
`default_nettype wire

// File: tb/tb_ex_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_div
// Description : Directed self-checking bench for ex_div: reset values,
//               unsigned and signed division, divide by zero, flush abort,
//               back-to-back operations and reset during an operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_div;
  import ex_div_pkg::*;

  localparam int W = 32;

  logic         cpu_clk_75M = 1'b0;
  logic         cpu_rst;
  logic         div_start_i;
  logic         div_signed_i;
  logic [W-1:0] dividend_i;
  logic [W-1:0] divisor_i;
  logic         flush_i;
  logic         stop_o;
  logic         ready_o;
  logic [W-1:0] quot_o;
  logic [W-1:0] rem_o;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_dz_lat;

  always #5 cpu_clk_75M = ~cpu_clk_75M;

  ex_div #(
    .WIDTH (W),
    .CNT_W (6)
  ) dut (
    .cpu_clk_75M  (cpu_clk_75M),
    .cpu_rst      (cpu_rst),
    .div_start_i  (div_start_i),
    .div_signed_i (div_signed_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .flush_i      (flush_i),
    .stop_o       (stop_o),
    .ready_o      (ready_o),
    .quot_o       (quot_o),
    .rem_o        (rem_o)
  );

  // Issue one division, hold start while stalled, and report the cycle of
  // ready_o (cycle 0 = accept cycle), the number of stalled cycles and the
  // results. lat stays -1 if no ready_o arrives within the budget.
  task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int stops, output logic stop_at_ready,
                         output logic [W-1:0] q, output logic [W-1:0] r);
    int k;
    bit done;
    @(negedge cpu_clk_75M);
    div_start_i  = 1'b1;
    div_signed_i = sgn;
    dividend_i   = a;
    divisor_i    = b;
    lat = -1; stops = 0; stop_at_ready = 1'b1; q = '0; r = '0;
    k = 0; done = 1'b0;
    while (!done && k < 100) begin
      #1;
      if (stop_o) stops++;
      if (ready_o) begin
        lat = k; stop_at_ready = stop_o; q = quot_o; r = rem_o; done = 1'b1;
      end
      @(negedge cpu_clk_75M);
      k++;
    end
    div_start_i = 1'b0;
  endtask

  task automatic test_reset();
    cpu_rst = 1'b1;
    repeat (3) @(negedge cpu_clk_75M);
    #1;
    n_tests++; if (stop_o !== 1'b0) begin n_fail++; $display("FAIL reset_stop: got %b want 0", stop_o); end
    n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    n_tests++; if (quot_o !== '0) begin n_fail++; $display("FAIL reset_quot: got %h want 0", quot_o); end
    n_tests++; if (rem_o !== '0) begin n_fail++; $display("FAIL reset_rem: got %h want 0", rem_o); end
    cpu_rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat, stops;
    logic sar;
    logic [W-1:0] q, r;
    run_div(DivUnsigned, 32'd100, 32'd7, lat, stops, sar, q, r);
    n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL udiv_latency: got %0d want 33", lat); end
    n_tests++; if (stops !== 33) begin n_fail++; $display("FAIL udiv_stall_cycles: got %0d want 33", stops); end
    n_tests++; if (sar !== 1'b0) begin n_fail++; $display("FAIL udiv_stop_in_done: got %b want 0", sar); end
    n_tests++; if (q !== 32'd14) begin n_fail++; $display("FAIL udiv_quot: got %h want %h", q, 32'd14); end
    n_tests++; if (r !== 32'd2) begin n_fail++; $display("FAIL udiv_rem: got %h want %h", r, 32'd2); end
    #1;
    n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL udiv_ready_strobe: got %b want 0", ready_o); end
    n_tests++; if (quot_o !== 32'd14) begin n_fail++; $display("FAIL udiv_quot_hold: got %h want %h", quot_o, 32'd14); end

    run_div(DivUnsigned, 32'hFFFF_FFFF, 32'h10, lat, stops, sar, q, r);
    n_tests++; if (q !== 32'h0FFF_FFFF) begin n_fail++; $display("FAIL udiv_big_quot: got %h want 0fffffff", q); end
    n_tests++; if (r !== 32'hF) begin n_fail++; $display("FAIL udiv_big_rem: got %h want 0000000f", r); end

    run_div(DivUnsigned, 32'h8000_0000, 32'hFFFF_FFFF, lat, stops, sar, q, r);
    n_tests++; if (q !== 32'h0) begin n_fail++; $display("FAIL udiv_min_quot: got %h want 00000000", q); end
    n_tests++; if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL udiv_min_rem: got %h want 80000000", r); end
  endtask

  task automatic test_signed();
    int lat, stops;
    logic sar;
    logic [W-1:0] q, r;
    run_div(DivSigned, 32'hFFFF_FFF9, 32'd2, lat, stops, sar, q, r);
    n_tests++; if (q !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL sdiv_m7_2_quot: got %h want fffffffd", q); end
    n_tests++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sdiv_m7_2_rem: got %h want ffffffff", r); end

    run_div(DivSigned, 32'h8000_0000, 32'hFFFF_FFFF, lat, stops, sar, q, r);
    n_tests++; if (q !== 32'h8000_0000) begin n_fail++; $display("FAIL sdiv_ovf_quot: got %h want 80000000", q); end
    n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL sdiv_ovf_rem: got %h want 00000000", r); end
    n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL sdiv_ovf_latency: got %0d want 33", lat); end

    run_div(DivSigned, 32'd7, 32'hFFFF_FFFE, lat, stops, sar, q, r);
    n_tests++; if (q !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL sdiv_7_m2_quot: got %h want fffffffd", q); end
    n_tests++; if (r !== 32'd1) begin n_fail++; $display("FAIL sdiv_7_m2_rem: got %h want 00000001", r); end
  endtask

  task automatic test_div_zero();
    int lat, stops;
    logic sar;
    logic [W-1:0] q, r;
    run_div(DivSigned, 32'h1234_5678, 32'h0, lat, stops, sar, q, r);
    n_tests++; if (q !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_quot: got %h want ffffffff", q); end
    n_tests++; if (r !== 32'h1234_5678) begin n_fail++; $display("FAIL dz_rem: got %h want 12345678", r); end
    n_tests++; if (lat !== exp_dz_lat) begin n_fail++; $display("FAIL dz_latency: got %0d want %0d", lat, exp_dz_lat); end
    n_tests++; if (stops !== exp_dz_lat) begin n_fail++; $display("FAIL dz_stall_cycles: got %0d want %0d", stops, exp_dz_lat); end

    run_div(DivSigned, 32'h8765_4321, 32'h0, lat, stops, sar, q, r);
    n_tests++; if (q !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_neg_quot: got %h want ffffffff", q); end
    n_tests++; if (r !== 32'h8765_4321) begin n_fail++; $display("FAIL dz_neg_rem: got %h want 87654321", r); end
  endtask

  task automatic test_flush();
    int lat, stops;
    logic sar;
    logic [W-1:0] q, r;
    @(negedge cpu_clk_75M);
    div_start_i = 1'b1; div_signed_i = DivUnsigned; dividend_i = 32'd100; divisor_i = 32'd7;
    repeat (10) @(negedge cpu_clk_75M);
    flush_i = 1'b1;
    #1;
    n_tests++; if (stop_o !== 1'b0) begin n_fail++; $display("FAIL flush_stop_comb: got %b want 0", stop_o); end
    n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_ready_comb: got %b want 0", ready_o); end
    @(negedge cpu_clk_75M);
    flush_i = 1'b0; div_start_i = 1'b0;
    #1;
    n_tests++; if (stop_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle_stop: got %b want 0", stop_o); end
    // A stale completion of the aborted op would appear at lat 21, not 33
    run_div(DivSigned, 32'hFFFF_FC18, 32'd3, lat, stops, sar, q, r);
    n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL flush_next_latency: got %0d want 33", lat); end
    n_tests++; if (q !== 32'hFFFF_FEB3) begin n_fail++; $display("FAIL flush_next_quot: got %h want fffffeb3", q); end
    n_tests++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL flush_next_rem: got %h want ffffffff", r); end
  endtask

  task automatic test_back_to_back();
    int t, t1, t2;
    logic [W-1:0] q1, r1, q2, r2;
    @(negedge cpu_clk_75M);
    div_start_i = 1'b1; div_signed_i = DivUnsigned; dividend_i = 32'd50; divisor_i = 32'd5;
    t = 0; t1 = -1; t2 = -1; q1 = '0; r1 = '0; q2 = '0; r2 = '0;
    while (t2 < 0 && t < 120) begin
      #1;
      if (ready_o) begin
        if (t1 < 0) begin
          t1 = t; q1 = quot_o; r1 = rem_o;
          dividend_i = 32'd9; divisor_i = 32'd4;
        end else begin
          t2 = t; q2 = quot_o; r2 = rem_o;
        end
      end
      @(negedge cpu_clk_75M);
      t++;
    end
    div_start_i = 1'b0;
    n_tests++; if (t1 !== 33) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 33", t1); end
    n_tests++; if ((t2 - t1) !== 34) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 34", t2 - t1); end
    n_tests++; if (q1 !== 32'd10) begin n_fail++; $display("FAIL b2b_quot1: got %h want 0000000a", q1); end
    n_tests++; if (r1 !== 32'd0) begin n_fail++; $display("FAIL b2b_rem1: got %h want 00000000", r1); end
    n_tests++; if (q2 !== 32'd2) begin n_fail++; $display("FAIL b2b_quot2: got %h want 00000002", q2); end
    n_tests++; if (r2 !== 32'd1) begin n_fail++; $display("FAIL b2b_rem2: got %h want 00000001", r2); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge cpu_clk_75M);
    div_start_i = 1'b1; div_signed_i = DivUnsigned; dividend_i = 32'd1000; divisor_i = 32'd7;
    repeat (20) @(negedge cpu_clk_75M);
    cpu_rst = 1'b1;
    @(negedge cpu_clk_75M);
    cpu_rst = 1'b0; div_start_i = 1'b0;
    #1;
    n_tests++; if (stop_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_stop: got %b want 0", stop_o); end
    n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b want 0", ready_o); end
    n_tests++; if (quot_o !== '0) begin n_fail++; $display("FAIL rstmid_quot: got %h want 0", quot_o); end
    n_tests++; if (rem_o !== '0) begin n_fail++; $display("FAIL rstmid_rem: got %h want 0", rem_o); end
    pulses = 0;
    repeat (40) begin
      @(negedge cpu_clk_75M);
      #1;
      if (ready_o) pulses++;
    end
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL rstmid_no_ready: got %0d pulses want 0", pulses); end
  endtask

  initial begin
`ifdef DIV_ZERO_FAST_EN
    exp_dz_lat = 1;
`else
    exp_dz_lat = 33;
`endif
    cpu_rst      = 1'b1;
    div_start_i  = 1'b0;
    div_signed_i = DivUnsigned;
    dividend_i   = '0;
    divisor_i    = '0;
    flush_i      = 1'b0;

    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_flush();
    test_back_to_back();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ex_div
`default_nettype wire
